// File: rtl/mem_wb_access.sv
// Memory stage bus access and M->W pipeline register.
// Supports single- and multi-cycle data-memory handshakes, misalignment detection and a wait timeout.
module mem_wb_access #(
  parameter int word_width = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic                  MemWriteM,
  input  logic [2:0]            funct3M,
  input  logic [word_width-1:0] ALUResultM,
  input  logic [word_width-1:0] WriteDataM,
  input  logic [4:0]            RdM,
  input  logic [word_width-1:0] PCPlus4M,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [word_width-1:0] dmem_addr,
  output logic [31:0]           dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic [31:0]           dmem_rdata,
  input  logic                  dmem_ack,
  output logic                  StallM,
  output logic                  RegWriteW,
  output logic [1:0]            ResultSrcW,
  output logic [word_width-1:0] ALUResultW,
  output logic [word_width-1:0] ReadDataW,
  output logic [4:0]            RdW,
  output logic [word_width-1:0] PCPlus4W,
  output logic                  MisalignW,
  output logic                  BusErrW
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t state, state_n;
  logic [7:0] cnt;
  logic load, access, misalign, aligned_acc, timeout;
  logic [1:0] ofs;
  logic [31:0] lane;
  logic [word_width-1:0] ld_data;

  assign ofs         = ALUResultM[1:0];
  assign load        = (ResultSrcM == 2'b01);
  assign access      = MemWriteM | load;
  assign misalign    = access & (((funct3M[1:0] == 2'b01) & ofs[0]) |
                                 ((funct3M[1:0] == 2'b10) & (ofs != 2'b00)));
  assign aligned_acc = access & ~misalign;
  assign timeout     = (state == S_WAIT) && (cnt >= TO);

  // rst_n gates the bus and stall combinationally so reset wins immediately
  assign dmem_req  = rst_n & aligned_acc;
  assign StallM    = rst_n & aligned_acc & ~dmem_ack & ~timeout;
  assign dmem_we   = MemWriteM;
  assign dmem_addr = {ALUResultM[word_width-1:2], 2'b00};

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = WriteDataM[31:0];
    if (MemWriteM) begin
      case (funct3M[1:0])
        2'b00: begin
          dmem_be    = 4'b0001 << ofs;
          dmem_wdata = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          dmem_be    = 4'b0011 << ofs;
          dmem_wdata = {2{WriteDataM[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign lane = dmem_rdata >> {ofs, 3'b000};
  always_comb begin
    ld_data = word_width'(dmem_rdata);
    case (funct3M)
      3'b000:  ld_data = {{(word_width-8){lane[7]}}, lane[7:0]};
      3'b001:  ld_data = {{(word_width-16){lane[15]}}, lane[15:0]};
      3'b100:  ld_data = {{(word_width-8){1'b0}}, lane[7:0]};
      3'b101:  ld_data = {{(word_width-16){1'b0}}, lane[15:0]};
      default: ;
    endcase
  end

  // Leaving WAIT also covers the M stage dropping the access (e.g. a flush)
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (aligned_acc && !dmem_ack) state_n = S_WAIT;
      S_WAIT:  if (dmem_ack || timeout || !aligned_acc) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state_n == S_IDLE)  cnt <= '0;
      else if (state == S_IDLE) cnt <= 8'd1;
      else                    cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || StallM) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      RdW        <= '0;
      PCPlus4W   <= '0;
      MisalignW  <= 1'b0;
      BusErrW    <= 1'b0;
    end else begin
      RegWriteW  <= RegWriteM & ~misalign & ~timeout;
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= (load & ~misalign & ~timeout) ? ld_data : '0;
      RdW        <= RdM;
      PCPlus4W   <= PCPlus4M;
      MisalignW  <= misalign;
      BusErrW    <= timeout;
    end
  end
endmodule
